// File: rtl/ram_port_arbiter_if.sv
// CPU-side fetch/load-store ports plus the RAM-side strobe bus of the arbiter.
// The slave modport belongs to the arbiter, the master modport to the core/RAM side.
interface ram_port_arbiter_if #(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  I_REQ;
  logic [ADDR_BITS-1:0]  I_ADDR;
  logic                  I_ACK;
  logic                  I_RVALID;
  logic [DATA_WIDTH-1:0] I_RDATA;

  logic                  D_REQ;
  logic                  D_WE;
  logic [ADDR_BITS-1:0]  D_ADDR;
  logic [DATA_WIDTH-1:0] D_WDATA;
  logic                  D_ACK;
  logic                  D_RVALID;
  logic [DATA_WIDTH-1:0] D_RDATA;

  logic                  RAM_ENABLE;
  logic                  RAM_WRITE;
  logic [ADDR_BITS-1:0]  RAM_ADDR;
  logic [DATA_WIDTH-1:0] RAM_DATA_IN;
  logic [DATA_WIDTH-1:0] RAM_DATA_OUT;

  logic                  BUSY;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, RAM_DATA_OUT,
    output I_ACK, I_RVALID, I_RDATA, D_ACK, D_RVALID, D_RDATA,
           RAM_ENABLE, RAM_WRITE, RAM_ADDR, RAM_DATA_IN, BUSY
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, RAM_DATA_OUT,
    input  I_ACK, I_RVALID, I_RDATA, D_ACK, D_RVALID, D_RDATA,
           RAM_ENABLE, RAM_WRITE, RAM_ADDR, RAM_DATA_IN, BUSY
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Fetch / load-store front end for a single-port RAM with 1-cycle registered read data.
// Define ARB_ROUND_ROBIN_EN for alternating grants on conflict; default is fixed D-over-I.
module ram_port_arbiter #(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  win_d_q, win_d_d;   // 1: D port owns the access in flight
  logic                  rd_q, rd_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  i_rvalid_q, i_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  busy_q, busy_d;
  logic                  any_req, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_d_q, last_d_d;
  assign pick_d = bus.D_REQ & (~bus.I_REQ | ~last_d_q);
`else
  assign pick_d = bus.D_REQ;
`endif

  assign any_req = bus.I_REQ | bus.D_REQ;

  always_comb begin
    state_d     = state_q;
    win_d_d     = win_d_q;
    rd_d        = rd_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d    = ISSUE;
          win_d_d    = pick_d;
          rd_d       = pick_d ? ~bus.D_WE : 1'b1;
          ram_en_d   = 1'b1;
          ram_we_d   = pick_d & bus.D_WE;
          ram_addr_d = pick_d ? bus.D_ADDR : bus.I_ADDR;
          // Write data only changes on stores; reads leave the last store data on the bus.
          if (pick_d && bus.D_WE) ram_wdata_d = bus.D_WDATA;
          i_ack_d    = ~pick_d;
          d_ack_d    = pick_d;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d   = pick_d;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        if (rd_q) begin
          if (win_d_q) begin
            d_rdata_d  = bus.RAM_DATA_OUT;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = bus.RAM_DATA_OUT;
            i_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      win_d_q     <= 1'b0;
      rd_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_d_q     <= win_d_d;
      rd_q        <= rd_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign bus.I_ACK       = i_ack_q;
  assign bus.D_ACK       = d_ack_q;
  assign bus.I_RVALID    = i_rvalid_q;
  assign bus.D_RVALID    = d_rvalid_q;
  assign bus.I_RDATA     = i_rdata_q;
  assign bus.D_RDATA     = d_rdata_q;
  assign bus.RAM_ENABLE  = ram_en_q;
  assign bus.RAM_WRITE   = ram_we_q;
  assign bus.RAM_ADDR    = ram_addr_q;
  assign bus.RAM_DATA_IN = ram_wdata_q;
  assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: slot-level reference model (one access per 3-cycle slot)
// scheduling expected per-cycle outputs, checked against the DUT plus a behavioural RAM.
module tb_ram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int N  = 4300;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ram_port_arbiter_if #(.ADDR_BITS(AW), .DATA_WIDTH(DW)) bus();
  ram_port_arbiter #(.ADDR_BITS(AW), .DATA_WIDTH(DW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  // Behavioural single-port RAM with registered read data and a preload port
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ram_q = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge CLK) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.RAM_ENABLE) begin
      if (bus.RAM_WRITE) ram[bus.RAM_ADDR] <= bus.RAM_DATA_IN;
      else               ram_q <= ram[bus.RAM_ADDR];
    end
  end
  assign bus.RAM_DATA_OUT = ram_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester state
  bit            i_pend = 0, d_pend = 0, d_we = 0, rnd_en = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wd = '0;

  // per-cycle expectations
  bit            e_iack [N], e_dack [N], e_irv [N], e_drv [N], e_en [N], e_busy [N];
  bit            e_upd [N], e_we [N], e_wdu [N], e_zero [N];
  logic [AW-1:0] e_addr [N];
  logic [DW-1:0] e_wd [N], e_rd [N];
  logic [DW-1:0] ref_mem [0:4095];
  int            free_at = 0;
  bit            last_d = 0;

  // held output values
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wd, h_ird, h_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 33);
    return (r == 33) ? 12'hFFF : 12'(r);
  endfunction

  // Model of what the DUT does with the inputs sampled at edge e
  task automatic model_edge(input int e, input bit rst);
    bit gd, pref_d;
    if (e + 4 >= N) return;
    if (rst) begin
      for (int c = e + 1; c <= e + 3; c++) begin
        e_iack[c] = 0; e_dack[c] = 0; e_irv[c] = 0; e_drv[c] = 0;
        e_en[c] = 0; e_busy[c] = 0; e_upd[c] = 0; e_wdu[c] = 0;
      end
      e_zero[e+1] = 1;
      free_at = e + 1;
      last_d = 0;
      return;
    end
    if (e < free_at || !(i_pend || d_pend)) return;
`ifdef ARB_ROUND_ROBIN_EN
    pref_d = !last_d;
`else
    pref_d = 1;
`endif
    gd = d_pend && (!i_pend || pref_d);
    last_d = gd;
    e_iack[e+1] = !gd;
    e_dack[e+1] = gd;
    e_en[e+1]   = 1;
    e_upd[e+1]  = 1;
    for (int c = e + 1; c <= e + 3; c++) e_busy[c] = 1;
    if (gd) begin
      e_addr[e+1] = d_addr;
      e_we[e+1]   = d_we;
      if (d_we) begin
        e_wdu[e+1] = 1; e_wd[e+1] = d_wd;
        ref_mem[d_addr] = d_wd;
      end else begin
        e_drv[e+3] = 1; e_rd[e+3] = ref_mem[d_addr];
      end
    end else begin
      e_addr[e+1] = i_addr;
      e_we[e+1]   = 0;
      e_irv[e+3]  = 1; e_rd[e+3] = ref_mem[i_addr];
    end
    free_at = e + 3;
  endtask

  task automatic check_cycle(input int c);
    if (c >= N) return;
    if (e_zero[c]) begin
      h_addr = '0; h_we = 0; h_wd = '0; h_ird = '0; h_drd = '0;
    end
    if (e_upd[c]) begin h_addr = e_addr[c]; h_we = e_we[c]; end
    if (e_wdu[c]) h_wd = e_wd[c];
    if (e_irv[c]) h_ird = e_rd[c];
    if (e_drv[c]) h_drd = e_rd[c];
    chk("I_ACK",       32'(bus.I_ACK),       32'(e_iack[c]));
    chk("D_ACK",       32'(bus.D_ACK),       32'(e_dack[c]));
    chk("I_RVALID",    32'(bus.I_RVALID),    32'(e_irv[c]));
    chk("D_RVALID",    32'(bus.D_RVALID),    32'(e_drv[c]));
    chk("I_RDATA",     32'(bus.I_RDATA),     32'(h_ird));
    chk("D_RDATA",     32'(bus.D_RDATA),     32'(h_drd));
    chk("RAM_ENABLE",  32'(bus.RAM_ENABLE),  32'(e_en[c]));
    chk("RAM_WRITE",   32'(bus.RAM_WRITE),   32'(h_we));
    chk("RAM_ADDR",    32'(bus.RAM_ADDR),    32'(h_addr));
    chk("RAM_DATA_IN", 32'(bus.RAM_DATA_IN), 32'(h_wd));
    chk("BUSY",        32'(bus.BUSY),        32'(e_busy[c]));
  endtask

  task automatic tick(input bit rst);
    if (rnd_en) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = rnd_addr();
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wd = DW'($urandom);
      end
    end
    RESET       = rst;
    bus.I_REQ   = i_pend;
    bus.I_ADDR  = i_pend ? i_addr : rnd_addr();
    bus.D_REQ   = d_pend;
    bus.D_WE    = d_pend ? d_we : 1'($urandom_range(0, 1));
    bus.D_ADDR  = d_pend ? d_addr : rnd_addr();
    bus.D_WDATA = d_pend ? d_wd : DW'($urandom);
    model_edge(cyc, rst);
    @(posedge CLK);
    #1;
    cyc++;
    check_cycle(cyc);
    if (cyc < N && e_iack[cyc]) i_pend = 0;
    if (cyc < N && e_dack[cyc]) d_pend = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick(0);
  endtask

  initial begin
    RESET = 1;
    // Reset with preload; random requests while in reset must be ignored
    for (int a = 0; a <= 33; a++) begin
      pl_en   = 1;
      pl_addr = (a == 33) ? 12'hFFF : 12'(a);
      pl_data = (a == 16) ? 16'h1111 : (a == 32) ? 16'h2222 : (a == 33) ? 16'hA5A5 : DW'($urandom);
      ref_mem[pl_addr] = pl_data;
      i_pend = 1'($urandom_range(0, 1)); i_addr = rnd_addr();
      d_pend = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
      d_addr = rnd_addr(); d_wd = DW'($urandom);
      tick(1);
    end
    pl_en = 0;
    i_pend = 0; d_pend = 0;
    tick(1);

    // store then fetch of the same word
    d_pend = 1; d_we = 1; d_addr = 12'h005; d_wd = 16'hBEEF;
    run(4);
    i_pend = 1; i_addr = 12'h005;
    run(4);

    // simultaneous fetch and load
    i_pend = 1; i_addr = 12'h010;
    d_pend = 1; d_we = 0; d_addr = 12'h020;
    run(8);

    // both ports requesting continuously
    for (int k = 0; k < 13; k++) begin
      if (!i_pend) begin i_pend = 1; i_addr = rnd_addr(); end
      if (!d_pend) begin d_pend = 1; d_we = 0; d_addr = rnd_addr(); end
      tick(0);
    end
    run(10);
    i_pend = 0; d_pend = 0;
    run(2);

    // reset during WAIT of a load
    d_pend = 1; d_we = 0; d_addr = 12'h007;
    tick(0); tick(0); tick(1);
    d_pend = 0;
    run(4);

    // last word
    d_pend = 1; d_we = 0; d_addr = 12'hFFF;
    run(5);

    // random traffic with occasional resets
    rnd_en = 1;
    for (int k = 0; k < 3000; k++) tick($urandom_range(0, 149) == 0);
    rnd_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
